// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I decode constants and decoded-bundle type shared by the decode stage.
package decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [1:0] ALU_M   = 2'b10;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic       write_en;
        logic       mem_write_en;
        logic       mem_read_en;
        logic       branch_inst;
        logic       jump_inst;
        logic       jalr_inst;
        logic       system_inst;
        logic       illegal_inst;
        logic       alu_src1_from_pc;
        logic       alu_src2_from_imm;
        logic [4:0] write_addr;
        logic [4:0] read_addr1;
        logic [4:0] read_addr2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] alu_opcode;
    } dec_bundle_t;

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - Purely combinational RV32I decode; DECODE_RV32M_EN adds M-extension decode.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output dec_bundle_t     bundle,
    output logic [XLEN-1:0] imm
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic        legal;
    logic        rd_write;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm    = XLEN'($signed(imm32));

    always_comb begin
        bundle            = '0;
        imm32             = '0;
        legal             = 1'b1;
        rd_write          = 1'b0;
        bundle.write_addr = inst[11:7];
        bundle.read_addr1 = inst[19:15];
        bundle.read_addr2 = inst[24:20];
        bundle.funct3     = f3;
        bundle.funct7     = f7;

        case (opcode)
            OP: begin
                rd_write = 1'b1;
                if (f7 == F7_BASE) begin
                    bundle.alu_opcode = {2'b00, f3};
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    bundle.alu_opcode = {2'b01, f3};
`ifdef DECODE_RV32M_EN
                end else if (f7 == F7_MULDIV) begin
                    bundle.alu_opcode = {ALU_M, f3};
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            OP_IMM: begin
                rd_write                 = 1'b1;
                bundle.alu_src2_from_imm = 1'b1;
                imm32                    = {{20{inst[31]}}, inst[31:20]};
                bundle.alu_opcode        = {1'b0, (f3 == 3'b101) ? inst[30] : 1'b0, f3};
                if (f3 == 3'b001 && f7 != F7_BASE) legal = 1'b0;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) legal = 1'b0;
            end
            LOAD: begin
                rd_write                 = 1'b1;
                bundle.mem_read_en       = 1'b1;
                bundle.alu_src2_from_imm = 1'b1;
                bundle.alu_opcode        = ALU_ADD;
                imm32                    = {{20{inst[31]}}, inst[31:20]};
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) legal = 1'b0;
            end
            STORE: begin
                bundle.mem_write_en      = 1'b1;
                bundle.alu_src2_from_imm = 1'b1;
                bundle.alu_opcode        = ALU_ADD;
                imm32                    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                if (f3 > 3'b010) legal = 1'b0;
            end
            BRANCH: begin
                bundle.branch_inst = 1'b1;
                bundle.alu_opcode  = {2'b00, f3};
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                if (f3 == 3'b010 || f3 == 3'b011) legal = 1'b0;
            end
            LUI: begin
                // Computed as x0 + imm, so the rs1 field bits (part of the immediate) are masked.
                rd_write                 = 1'b1;
                bundle.read_addr1        = 5'd0;
                bundle.alu_src2_from_imm = 1'b1;
                bundle.alu_opcode        = ALU_ADD;
                imm32                    = {inst[31:12], 12'b0};
            end
            AUIPC: begin
                rd_write                 = 1'b1;
                bundle.alu_src1_from_pc  = 1'b1;
                bundle.alu_src2_from_imm = 1'b1;
                bundle.alu_opcode        = ALU_ADD;
                imm32                    = {inst[31:12], 12'b0};
            end
            JAL: begin
                rd_write                 = 1'b1;
                bundle.jump_inst         = 1'b1;
                bundle.alu_src1_from_pc  = 1'b1;
                bundle.alu_src2_from_imm = 1'b1;
                bundle.alu_opcode        = ALU_ADD;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            JALR: begin
                rd_write                 = 1'b1;
                bundle.jalr_inst         = 1'b1;
                bundle.alu_src2_from_imm = 1'b1;
                bundle.alu_opcode        = ALU_ADD;
                imm32                    = {{20{inst[31]}}, inst[31:20]};
                if (f3 != 3'b000) legal = 1'b0;
            end
            FENCE: begin
            end
            SYSTEM: begin
                if (inst == INST_ECALL || inst == INST_EBREAK) bundle.system_inst = 1'b1;
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        if (inst[1:0] != 2'b11) legal = 1'b0;

        bundle.write_en = rd_write && (bundle.write_addr != 5'd0);

        if (!legal) begin
            bundle.write_en          = 1'b0;
            bundle.mem_write_en      = 1'b0;
            bundle.mem_read_en       = 1'b0;
            bundle.branch_inst       = 1'b0;
            bundle.jump_inst         = 1'b0;
            bundle.jalr_inst         = 1'b0;
            bundle.system_inst       = 1'b0;
            bundle.alu_src1_from_pc  = 1'b0;
            bundle.alu_src2_from_imm = 1'b0;
            bundle.alu_opcode        = ALU_ADD;
            bundle.illegal_inst      = 1'b1;
            imm32                    = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Registered RV32I decode stage with handshake, flush and transfer counter (DECODE_RV32M_EN optional).
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [XLEN-1:0]  dec_pc,
    output logic             write_en,
    output logic             mem_write_en,
    output logic             mem_read_en,
    output logic             branch_inst,
    output logic             jump_inst,
    output logic             jalr_inst,
    output logic             system_inst,
    output logic             illegal_inst,
    output logic             alu_src1_from_pc,
    output logic             alu_src2_from_imm,
    output logic [4:0]       write_addr,
    output logic [4:0]       read_addr1,
    output logic [4:0]       read_addr2,
    output logic [XLEN-1:0]  immediate,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       alu_opcode,
    output logic [CNT_W-1:0] decode_count
);

    dec_bundle_t      comb_bundle;
    logic [XLEN-1:0]  comb_imm;

    dec_bundle_t      bundle_q, bundle_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             capture;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .inst   (in_inst),
        .bundle (comb_bundle),
        .imm    (comb_imm)
    );

    assign in_ready = !flush && (!valid_q || dec_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        bundle_d = bundle_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (capture) begin
            bundle_d = comb_bundle;
            imm_d    = comb_imm;
            pc_d     = in_pc;
        end
        if (flush)          valid_d = 1'b0;
        else if (capture)   valid_d = 1'b1;
        else if (dec_ready) valid_d = 1'b0;
        // A bundle killed by flush in the same cycle it is accepted is not counted.
        if (valid_q && dec_ready && !flush) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            bundle_q <= bundle_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign dec_valid         = valid_q;
    assign dec_pc            = pc_q;
    assign immediate         = imm_q;
    assign decode_count      = count_q;
    assign write_en          = bundle_q.write_en;
    assign mem_write_en      = bundle_q.mem_write_en;
    assign mem_read_en       = bundle_q.mem_read_en;
    assign branch_inst       = bundle_q.branch_inst;
    assign jump_inst         = bundle_q.jump_inst;
    assign jalr_inst         = bundle_q.jalr_inst;
    assign system_inst       = bundle_q.system_inst;
    assign illegal_inst      = bundle_q.illegal_inst;
    assign alu_src1_from_pc  = bundle_q.alu_src1_from_pc;
    assign alu_src2_from_imm = bundle_q.alu_src2_from_imm;
    assign write_addr        = bundle_q.write_addr;
    assign read_addr1        = bundle_q.read_addr1;
    assign read_addr2        = bundle_q.read_addr2;
    assign funct3            = bundle_q.funct3;
    assign funct7            = bundle_q.funct7;
    assign alu_opcode        = bundle_q.alu_opcode;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic        write_en, mem_write_en, mem_read_en, branch_inst, jump_inst;
    logic        jalr_inst, system_inst, illegal_inst, alu_src1_from_pc, alu_src2_from_imm;
    logic [4:0]  write_addr, read_addr1, read_addr2;
    logic [31:0] immediate;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  alu_opcode;
    logic [31:0] decode_count;

    int checks   = 0;
    int failures = 0;
    int exp_count;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_pc(dec_pc), .write_en(write_en),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .branch_inst(branch_inst),
        .jump_inst(jump_inst), .jalr_inst(jalr_inst), .system_inst(system_inst),
        .illegal_inst(illegal_inst), .alu_src1_from_pc(alu_src1_from_pc),
        .alu_src2_from_imm(alu_src2_from_imm), .write_addr(write_addr),
        .read_addr1(read_addr1), .read_addr2(read_addr2), .immediate(immediate),
        .funct3(funct3), .funct7(funct7), .alu_opcode(alu_opcode),
        .decode_count(decode_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; presents one instruction, captures it on the next edge.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        check("in_ready_issue", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("dec_valid", {31'b0, dec_valid}, 32'd1);
        check("decode_count", decode_count, exp_count);
        exp_count++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        dec_ready = 1'b1;
        exp_count = 0;
        #12;
        check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check("rst_count", decode_count, 32'd0);
        check("rst_illegal", {31'b0, illegal_inst}, 32'd0);
        check("rst_imm", immediate, 32'd0);
        check("rst_pc", dec_pc, 32'd0);
        check("rst_write_en", {31'b0, write_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(32'h0050_0093, 32'h0000_0100);
        check("addi_we", {31'b0, write_en}, 32'd1);
        check("addi_wa", {27'b0, write_addr}, 32'd1);
        check("addi_imm", immediate, 32'd5);
        check("addi_alu", {27'b0, alu_opcode}, 32'h00);
        check("addi_src2", {31'b0, alu_src2_from_imm}, 32'd1);
        check("addi_pc", dec_pc, 32'h0000_0100);

        issue(32'h4020_81B3, 32'h0000_0104);
        check("sub_alu", {27'b0, alu_opcode}, 32'h08);
        check("sub_ra1", {27'b0, read_addr1}, 32'd1);
        check("sub_ra2", {27'b0, read_addr2}, 32'd2);
        check("sub_wa", {27'b0, write_addr}, 32'd3);
        check("sub_imm", immediate, 32'd0);

        issue(32'h0220_81B3, 32'h0000_0108);
`ifdef DECODE_RV32M_EN
        check("mul_alu", {27'b0, alu_opcode}, 32'h10);
        check("mul_illegal", {31'b0, illegal_inst}, 32'd0);
        check("mul_we", {31'b0, write_en}, 32'd1);
`else
        check("mul_illegal", {31'b0, illegal_inst}, 32'd1);
        check("mul_we", {31'b0, write_en}, 32'd0);
        check("mul_alu", {27'b0, alu_opcode}, 32'h00);
`endif

        issue(32'h0020_A423, 32'h0000_010C);
        check("sw_mwe", {31'b0, mem_write_en}, 32'd1);
        check("sw_imm", immediate, 32'd8);
        check("sw_we", {31'b0, write_en}, 32'd0);

        issue(32'h0000_0013, 32'h0000_0110);
        check("nop_we", {31'b0, write_en}, 32'd0);
        check("nop_illegal", {31'b0, illegal_inst}, 32'd0);

        issue(32'hFFFF_FFFF, 32'h0000_0114);
        check("ones_illegal", {31'b0, illegal_inst}, 32'd1);
        check("ones_enables", {27'b0, write_en, mem_write_en, mem_read_en, branch_inst, jump_inst}, 32'd0);
        check("ones_imm", immediate, 32'd0);

        issue(32'h1234_52B7, 32'h0000_0118);
        check("lui_imm", immediate, 32'h1234_5000);
        check("lui_ra1", {27'b0, read_addr1}, 32'd0);
        check("lui_wa", {27'b0, write_addr}, 32'd5);

        issue(32'hFFDF_F0EF, 32'h0000_011C);
        check("jal_imm", immediate, 32'hFFFF_FFFC);
        check("jal_flags", {29'b0, jump_inst, alu_src1_from_pc, write_en}, 32'd7);

        issue(32'h0000_0073, 32'h0000_0120);
        check("ecall_sys", {30'b0, system_inst, illegal_inst}, 32'd2);

        issue(32'h0020_0073, 32'h0000_0124);
        check("sys_bad", {30'b0, system_inst, illegal_inst}, 32'd1);

        issue(32'h0000_90E7, 32'h0000_0128);
        check("jalr_bad", {30'b0, jalr_inst, illegal_inst}, 32'd1);

        issue(32'h4030_D093, 32'h0000_012C);
        check("srai_alu", {27'b0, alu_opcode}, 32'h0D);
        check("srai_illegal", {31'b0, illegal_inst}, 32'd0);

        // Stall with a competing input; nothing may move.
        dec_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h0050_0093;
        in_pc     = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_valid", {31'b0, dec_valid}, 32'd1);
            check("stall_pc", dec_pc, 32'h0000_012C);
            check("stall_alu", {27'b0, alu_opcode}, 32'h0D);
            check("stall_count", decode_count, 32'd11);
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_valid", {31'b0, dec_valid}, 32'd0);
        check("flush_count", decode_count, 32'd11);

        rst_n = 1'b0;
        #1;
        check("midrst_count", decode_count, 32'd0);
        check("midrst_pc", dec_pc, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        exp_count = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) issue(32'h0050_0093 + (i << 7), 32'h0000_0300 + i * 4);
        @(posedge clk);
        #1;
        check("b2b_count", decode_count, 32'd4);
        check("b2b_last_wa", {27'b0, write_addr}, 32'd4);

        // Flush coinciding with a downstream accept is not counted.
        issue(32'h0000_0013, 32'h0000_0400);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_acc_count", decode_count, 32'd4);
        check("flush_acc_valid", {31'b0, dec_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I instruction decode stage with a valid/ready handshake on both sides, placed between fetch and execute in the Eka core. It decodes every RV32I base opcode, including JALR, FENCE and SYSTEM, and flags illegal encodings. It suppresses register writes to x0, supports a synchronous pipeline flush, and counts instructions handed to execute. M-extension decode is optional at compile time.

## Interface
- `XLEN`, 32: datapath width; immediates are sign-extended to XLEN (`XLEN` ≥ 32).
- `CNT_W`, 32: width of `decode_count`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_inst`/`in_pc` valid.
- `in_ready` out 1: stage accepts input this cycle.
- `in_inst` in 32: instruction word.
- `in_pc` in XLEN: instruction address.
- `flush` in 1: synchronous kill of the held instruction.
- `dec_valid` out 1: decoded bundle valid.
- `dec_ready` in 1: execute accepts bundle.
- `dec_pc` out XLEN: captured PC.
- `write_en`, `mem_write_en`, `mem_read_en`, `branch_inst`, `jump_inst`, `jalr_inst`, `system_inst`, `illegal_inst` out 1 each: control flags.
- `alu_src1_from_pc`, `alu_src2_from_imm` out 1 each: ALU operand selects.
- `write_addr`, `read_addr1`, `read_addr2` out 5 each: rd, rs1, rs2.
- `immediate` out XLEN: selected immediate; 0 for R-type, FENCE, SYSTEM and illegal instructions.
- `funct3` out 3: `in_inst[14:12]`.
- `funct7` out 7: `in_inst[31:25]`.
- `alu_opcode` out 5: `{m, bit30, funct3}`.
- `decode_count` out CNT_W: number of bundles transferred to execute.

## Operation
- Combinational decode feeds a single output register.
- Capture occurs on `in_valid && in_ready`.
- `in_ready = !flush && (!dec_valid || dec_ready)`.
- Opcode decode:
  - OP-IMM: `alu_opcode = {0, funct3==101 ? bit30 : 0, funct3}`, imm I.
  - OP: `{0, bit30, funct3}`.
  - LOAD/STORE: ADD, imm I/S.
  - BRANCH: imm B.
  - LUI: ADD, imm U, `read_addr1` forced to 0.
  - AUIPC: ADD, src1 = PC, imm U.
  - JAL: `jump_inst`, src1 = PC, imm J.
  - JALR: `jalr_inst`, ADD, imm I, rs1 source.
  - FENCE: legal no-op.
  - SYSTEM: only `0x00000073` and `0x00100073` are legal; each sets `system_inst`.
- `write_en` is forced to 0 when `write_addr == 0`.
- Illegal encodings:
  - `in_inst[1:0] != 2'b11`, or an unlisted opcode.
  - OP funct7 not `0000000`; `0100000` is allowed only with funct3 000 or 101.
  - OP-IMM funct3 001 requires funct7 `0000000`; funct3 101 requires funct7 `0000000` or `0100000`.
  - LOAD funct3 ∈ {011, 110, 111}.
  - STORE funct3 > 010.
  - BRANCH funct3 ∈ {010, 011}.
  - JALR funct3 ≠ 000.
- On an illegal encoding: `illegal_inst = 1` and every other control flag and enable is 0.

## Timing
- Reset values:
  - `dec_valid = 0`, `decode_count = 0`.
  - All decoded outputs and `dec_pc` are 0; `illegal_inst = 0`.
- Latency: 1 cycle from capture to `dec_valid`.
- Throughput: one instruction per cycle while `dec_ready = 1`.
- Stall: while `dec_valid && !dec_ready`, outputs hold and `in_ready = 0`.
- `dec_valid` next state:
  - `flush`: 0.
  - Else capture: 1.
  - Else if `dec_ready`: 0.
  - Otherwise: hold.
- Decoded fields change only on capture; they hold their last values when `dec_valid` is low.
- `decode_count` increments on `dec_valid && dec_ready && !flush` and wraps modulo 2^CNT_W.
- A flush in the same cycle as a downstream accept does not count.
- Reset asserted mid-stream clears all state immediately; the first capture is possible on the first edge after deassertion.

## Configuration
- `DECODE_RV32M_EN` defined:
  - OP with funct7 `0000001` is legal.
  - `alu_opcode = {1, 0, funct3}`; `write_en` per the normal rd rule.
- `DECODE_RV32M_EN` undefined: OP with funct7 `0000001` is illegal and `alu_opcode[4]` is always 0.

## Structure
- Package `decode_pkg`:
  - Opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, FENCE, SYSTEM).
  - ALU opcode constants.
  - funct7 constants.
  - The decoded-bundle struct typedef.
- Sub-module `decode_comb`: purely combinational decode of `in_inst` into the bundle, with XLEN as its parameter.
- `decode_stage` contains the handshake, output register, flush and counter.

## Test plan
- `in_inst = 0x00500093` (addi x1,x0,5), `dec_ready = 1` → next cycle:
  - `dec_valid = 1`, `write_en = 1`, `write_addr = 1`, `immediate = 5`.
  - `alu_opcode = 0x00`, `alu_src2_from_imm = 1`.
- `0x402081B3` (sub x3,x1,x2) → `alu_opcode = 0x08`, `read_addr1 = 1`, `read_addr2 = 2`, `write_addr = 3`.
- `0x022081B3` (mul):
  - With `DECODE_RV32M_EN`: `alu_opcode = 0x10`, `illegal_inst = 0`.
  - Without it: `illegal_inst = 1`, `write_en = 0`.
- `0x0020A423` (sw x2,8(x1)) → `mem_write_en = 1`, `immediate = 8`, `write_en = 0`.
- `0x00000013` (nop), then `0xFFFFFFFF`:
  - nop → `write_en = 0`, `illegal_inst = 0`.
  - `0xFFFFFFFF` → `illegal_inst = 1`, all enables 0, `immediate = 0`.
- Stall and flush sequence:
  - Hold `dec_ready = 0` for 3 cycles → `in_ready = 0` and outputs stable.
  - Assert `flush` → `dec_valid = 0` next cycle, `decode_count` unchanged.
  - 4 back-to-back transfers → `decode_count = 4`.
